i2s_dac_transmit: RTL and testbench

- Audio playback path for the codec DAC; the counterpart of the microphone ADC receive path.
- Accepts mono W-bit samples over a valid/ready stream and buffers them in a small FIFO.
- Acts as I2S bus master: divides the system clock to generate the bit clock (dac_bclk) and word clock (dac_lrck), and serialises each sample MSB-first onto dac_dat in both the left and right slots.
- Sits between playback logic (tone or pitch feedback generator) and the AUD_BCLK / AUD_DACLRCK / AUD_DACDAT pins.
- The codec is configured in slave mode for the DAC path.

---
 rtl/audio_pkg.sv | 9 +
 rtl/sync_sample_fifo.sv | 68 ++++++
 rtl/i2s_dac_transmit.sv | 105 ++++++++++
 tb/tb_i2s_dac_transmit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the sample type for the codec playback/capture paths.
package audio_pkg;
    localparam int AUDIO_W        = 16;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int DAC_BCLK_DIV   = 6;
    localparam int DAC_FIFO_DEPTH = 4;

    typedef logic signed [AUDIO_W-1:0] sample_t;
endpackage

// File: rtl/sync_sample_fifo.sv
// Small single-clock sample FIFO with first-word-fall-through head and registered full/empty.
module sync_sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_data,
    output logic [AW:0]  o_count
);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_full;
    logic          r_empty;
    logic          w_do_push;
    logic          w_do_pop;

    // Gating uses the registered flags only, so a pop never frees room for a same-cycle push.
    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/i2s_dac_transmit.sv
// I2S master transmitter: buffers mono samples and plays each one in both slots of a frame.
module i2s_dac_transmit
    import audio_pkg::*;
#(
    parameter int W          = AUDIO_W,
    parameter int BCLK_DIV   = DAC_BCLK_DIV,
    parameter int SLOT_BITS  = I2S_SLOT_BITS,
    parameter int FIFO_DEPTH = DAC_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         dac_bclk,
    output logic         dac_lrck,
    output logic         dac_dat,
    output logic         underrun
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DW-1:0] r_div_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [W-1:0]  r_sample;
    logic          r_bclk;
    logic          r_lrck;
    logic          r_dat;
    logic          r_underrun;

    logic [DW-1:0] w_div_next;
    logic [BW-1:0] w_bit_next;
    logic [BW-1:0] w_pos;
    logic [W-1:0]  w_sample_next;
    logic [W-1:0]  w_bit_sel;
    logic          w_tick;
    logic          w_frame_end;
    logic          w_lrck_next;
    logic          w_dat_next;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [W-1:0]  w_fifo_head;
    logic [AW:0]   w_fifo_count;

    sync_sample_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid),
        .i_pop   (w_frame_end),
        .i_data  (in_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign in_ready = !w_fifo_full;

    assign w_tick      = (r_div_cnt == DW'(BCLK_DIV - 1));
    assign w_div_next  = w_tick ? '0 : r_div_cnt + 1'b1;
    assign w_frame_end = w_tick && (r_bit_cnt == BW'(2 * SLOT_BITS - 1));
    assign w_bit_next  = (r_bit_cnt == BW'(2 * SLOT_BITS - 1)) ? '0 : r_bit_cnt + 1'b1;
    assign w_lrck_next = (w_bit_next >= BW'(SLOT_BITS));
    assign w_pos       = w_lrck_next ? w_bit_next - BW'(SLOT_BITS) : w_bit_next;

    assign w_sample_next = w_frame_end ? (w_fifo_empty ? '0 : w_fifo_head) : r_sample;

    // Slot position p carries sample bit W-p; position 0 is the I2S delay bit and p > W pads with 0.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit_sel
        assign w_bit_sel[gi] = (w_pos == BW'(W - gi)) && w_sample_next[gi];
    end
    assign w_dat_next = |w_bit_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_sample   <= '0;
            r_bclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_dat      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_div_cnt  <= w_div_next;
            r_bclk     <= (w_div_next >= DW'(BCLK_DIV / 2));
            r_underrun <= w_frame_end && (w_fifo_count == '0);
            // Data and word clock move with the bclk falling edge so the codec sees them stable on the rise.
            if (w_tick) begin
                r_bit_cnt <= w_bit_next;
                r_lrck    <= w_lrck_next;
                r_dat     <= w_dat_next;
                r_sample  <= w_sample_next;
            end
        end
    end

    assign dac_bclk = r_bclk;
    assign dac_lrck = r_lrck;
    assign dac_dat  = r_dat;
    assign underrun = r_underrun;
endmodule

// File: tb/tb_i2s_dac_transmit.sv
// Randomized self-checking bench: a timeline model of the I2S frame plus a sample queue predicts every pin.
module tb_i2s_dac_transmit;
    import audio_pkg::*;

    localparam int W     = 16;
    localparam int DIV   = 6;
    localparam int SLOT  = 32;
    localparam int FRAME = DIV * 2 * SLOT;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         dac_bclk;
    logic         dac_lrck;
    logic         dac_dat;
    logic         underrun;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: k = clk edges since reset, queue of accepted samples, sample of the current frame.
    longint  k = 0;
    sample_t q[$];
    sample_t cur = '0;
    bit      exp_underrun = 1'b0;
    bit      exp_ready = 1'b1;
    bit      accepted = 1'b0;

    i2s_dac_transmit dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dac_bclk (dac_bclk),
        .dac_lrck (dac_lrck),
        .dac_dat  (dac_dat),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] pins();
        return {dac_bclk, dac_lrck, dac_dat, underrun, in_ready};
    endfunction

    function automatic logic [4:0] expected_pins();
        int  b;
        int  p;
        logic bclk;
        logic lrck;
        logic dat;
        bclk = (k % DIV) >= (DIV / 2);
        b    = int'((k / DIV) % (2 * SLOT));
        lrck = (b >= SLOT);
        p    = b % SLOT;
        dat  = (p >= 1 && p <= W) ? cur[W - p] : 1'b0;
        return {bclk, lrck, dat, exp_underrun, exp_ready};
    endfunction

    task automatic step(input bit rst, input bit valid, input logic [W-1:0] data);
        bit load;
        bit pre_ready;
        int pre_n;
        reset    = rst;
        in_valid = valid;
        in_data  = data;
        @(posedge clk);
        if (rst) begin
            k = 0;
            q.delete();
            cur = '0;
            exp_underrun = 1'b0;
            exp_ready = 1'b1;
            accepted = 1'b0;
        end else begin
            load      = (k % FRAME) == FRAME - 1;
            pre_ready = exp_ready;
            pre_n     = q.size();
            exp_underrun = load && (pre_n == 0);
            if (load) begin
                if (pre_n > 0) cur = q.pop_front();
                else           cur = '0;
            end
            accepted = valid && pre_ready;
            if (accepted) q.push_back(sample_t'(data));
            k++;
            exp_ready = (q.size() < 4);
        end
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 16'hFFFF);
            got = pins();
            vectors++;
            if (got !== 5'b00001) begin
                miscompares++;
                $display("FAIL reset cycle=%0d got=%b want=00001", i, got);
            end
        end
    endtask

    task automatic test_clock_gen();
        logic [4:0] got;
        logic [4:0] want;
        int und_pulses = 0;
        int dat_high = 0;
        int lrck_low = 0;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b0, '0);
            got = pins();
            want = expected_pins();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL clock_gen k=%0d got=%b want=%b", k, got, want);
            end
            if (underrun) und_pulses++;
            if (dac_dat) dat_high++;
            if (k >= FRAME && k < 2 * FRAME && !dac_lrck) lrck_low++;
        end
        vectors++;
        if (und_pulses !== 2) begin
            miscompares++;
            $display("FAIL clock_gen_underrun_count got=%0d want=2", und_pulses);
        end
        vectors++;
        if (dat_high !== 0) begin
            miscompares++;
            $display("FAIL clock_gen_dat_idle got=%0d want=0", dat_high);
        end
        vectors++;
        if (lrck_low !== 192) begin
            miscompares++;
            $display("FAIL clock_gen_lrck_low got=%0d want=192", lrck_low);
        end
    endtask

    task automatic test_serialisation();
        logic [4:0]  got;
        logic [4:0]  want;
        logic [63:0] cap = '0;
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 16'hA5C3);
        while (k < 2 * FRAME + 10) begin
            step(1'b0, 1'b0, '0);
            got = pins();
            want = expected_pins();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL serialisation k=%0d got=%b want=%b", k, got, want);
            end
            if (k >= FRAME && k < 2 * FRAME && (k % DIV) == DIV / 2) cap = {cap[62:0], dac_dat};
        end
        vectors++;
        if (cap !== {32'h52E1_8000, 32'h52E1_8000}) begin
            miscompares++;
            $display("FAIL serialisation_frame1 got=%h want=52e1800052e18000", cap);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] got;
        logic [4:0] want;
        int val = 1;
        step(1'b1, 1'b0, '0);
        while (k < 7 * FRAME + 10) begin
            step(1'b0, val <= 6, W'(val));
            if (accepted) val++;
            got = pins();
            want = expected_pins();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL backpressure k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] got;
        logic [4:0] want;
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, W'($urandom));
        step(1'b0, 1'b1, W'($urandom));
        while (k % FRAME != FRAME - 1) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, W'($urandom));
        vectors++;
        if (dut.u_fifo.o_count !== 3'd2) begin
            miscompares++;
            $display("FAIL simultaneous_count got=%0d want=2", dut.u_fifo.o_count);
        end
        while (k < 4 * FRAME + 10) begin
            step(1'b0, 1'b0, '0);
            got = pins();
            want = expected_pins();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL simultaneous k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [4:0] got;
        logic [4:0] want;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'($urandom));
        while (k % FRAME != FRAME - 1) step(1'b0, 1'b0, '0);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_ready_before got=%b want=0", in_ready);
        end
        step(1'b0, 1'b1, 16'h7FFF);
        vectors++;
        if (dut.u_fifo.o_count !== 3'd3) begin
            miscompares++;
            $display("FAIL full_pop_refused got=%0d want=3", dut.u_fifo.o_count);
        end
        step(1'b0, 1'b1, 16'h7FFF);
        vectors++;
        if (dut.u_fifo.o_count !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_retry got count=%0d ready=%b want count=4 ready=0",
                     dut.u_fifo.o_count, in_ready);
        end
        while (k < 5 * FRAME + 10) begin
            step(1'b0, 1'b0, '0);
            got = pins();
            want = expected_pins();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL full_pop k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [4:0] got;
        logic [4:0] want;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'($urandom));
        while (k < 40 * DIV) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        got = pins();
        vectors++;
        if (got !== 5'b00001 || dut.u_fifo.o_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_frame_reset got=%b empty=%b want=00001 empty=1", got, dut.u_fifo.o_empty);
        end
        while (k < FRAME + 20) begin
            step(1'b0, 1'b0, '0);
            got = pins();
            want = expected_pins();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mid_frame_restart k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [4:0] got;
        logic [4:0] want;
        step(1'b1, 1'b0, '0);
        while (k < 12 * FRAME) begin
            step(1'b0, $urandom_range(0, 299) < 2, W'($urandom));
            got = pins();
            want = expected_pins();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL random_stream k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clock_gen();
        test_serialisation();
        test_backpressure();
        test_simultaneous();
        test_full_pop();
        test_mid_frame_reset();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
